uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: frame shifter plus a one-entry holding buffer.
// Frames are start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
module uart_tx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clkTx,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] dataInput,
    input  logic                 txValid,
    output logic                 txReady,
    output logic                 serialOut,
    output logic                 busy,
    output logic                 txDone
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY_EN > 1 || PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY_EN and PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int unsigned      CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic [DATA_BITS-1:0]   buf_q, buf_d;
    logic                   full_q, full_d;
    logic                   ser_q, ser_d;
    logic                   done_q, done_d;
    logic                   ready_q;

    logic                   accept;
    logic                   bit_end;
    logic                   frame_end;

    assign accept    = txValid && ready_q;
    assign bit_end   = (cnt_q == CNT_LAST);
    assign frame_end = (state_q == STOP) && bit_end && (idx_q == STOP_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        buf_d   = buf_q;
        full_d  = full_q;
        ser_d   = ser_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                ser_d = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    ser_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == DATA_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            ser_d   = par_q;
                        end else begin
                            state_d = STOP;
                            ser_d   = 1'b1;
                            idx_d   = '0;
                        end
                    end else begin
                        ser_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    ser_d   = 1'b1;
                    idx_d   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        ser_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ser_d   = 1'b1;
            end
        endcase

        // A queued word takes priority at frame end; txReady is low then, so no accept can collide.
        if (frame_end && full_q) begin
            state_d = START;
            ser_d   = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = buf_q;
            par_d   = (^buf_q) ^ (PARITY_ODD != 0);
            full_d  = 1'b0;
        end else if (accept && (state_q == IDLE || frame_end)) begin
            state_d = START;
            ser_d   = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = dataInput;
            par_d   = (^dataInput) ^ (PARITY_ODD != 0);
        end else if (accept) begin
            buf_d  = dataInput;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clkTx or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            ser_q   <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
            ready_q <= !full_d;
        end
    end

    assign txReady   = ready_q;
    assign serialOut = ser_q;
    assign busy      = (state_q != IDLE);
    assign txDone    = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg at CLKS_PER_BIT=4 across
// 8N1, 8E1, 8O1 and 7N2 configurations.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din [4];
    logic       vld [4];
    logic       rdy [4];
    logic       ser [4];
    logic       bsy [4];
    logic       dn  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(4)) u_8n1 (
        .clkTx(clk), .reset(rst_n), .dataInput(din[0]), .txValid(vld[0]),
        .txReady(rdy[0]), .serialOut(ser[0]), .busy(bsy[0]), .txDone(dn[0])
    );

    uart_tx_cfg #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
        .clkTx(clk), .reset(rst_n), .dataInput(din[1]), .txValid(vld[1]),
        .txReady(rdy[1]), .serialOut(ser[1]), .busy(bsy[1]), .txDone(dn[1])
    );

    uart_tx_cfg #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
        .clkTx(clk), .reset(rst_n), .dataInput(din[2]), .txValid(vld[2]),
        .txReady(rdy[2]), .serialOut(ser[2]), .busy(bsy[2]), .txDone(dn[2])
    );

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
        .clkTx(clk), .reset(rst_n), .dataInput(din[3][6:0]), .txValid(vld[3]),
        .txReady(rdy[3]), .serialOut(ser[3]), .busy(bsy[3]), .txDone(dn[3])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept `word` on the next edge, then compare every cycle of the frame
    // against the hand-built bit list (bit 0 = start bit).
    task automatic check_frame(input int d, input logic [7:0] word,
                               input logic [19:0] bits, input int nbits, input string tag);
        chk({tag, " ready"}, 32'(rdy[d]), 32'd1);
        din[d] = word;
        vld[d] = 1'b1;
        step();
        vld[d] = 1'b0;
        din[d] = 8'($urandom);
        for (int k = 0; k < nbits * 4; k++) begin
            chk({tag, " ser"},  32'(ser[d]), 32'(bits[k / 4]));
            chk({tag, " busy"}, 32'(bsy[d]), 32'd1);
            chk({tag, " done"}, 32'(dn[d]),  32'd0);
            step();
        end
        chk({tag, " done_end"}, 32'(dn[d]),  32'd1);
        chk({tag, " busy_end"}, 32'(bsy[d]), 32'd0);
        chk({tag, " ser_end"},  32'(ser[d]), 32'd1);
        step();
        chk({tag, " done_clr"}, 32'(dn[d]),  32'd0);
    endtask

    initial begin
        logic [19:0] exp_b2b;
        logic        exp_rdy;

        for (int i = 0; i < 4; i++) begin
            din[i] = 8'h00;
            vld[i] = 1'b0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst ser",   32'(ser[i]), 32'd1);
            chk("rst ready", 32'(rdy[i]), 32'd0);
            chk("rst busy",  32'(bsy[i]), 32'd0);
            chk("rst done",  32'(dn[i]),  32'd0);
        end
        repeat (3) step();
        chk("rst held ser",   32'(ser[0]), 32'd1);
        chk("rst held ready", 32'(rdy[0]), 32'd0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) chk("ready after rst", 32'(rdy[i]), 32'd1);

        for (int k = 0; k < 6; k++) begin
            chk("idle ser",  32'(ser[0]), 32'd1);
            chk("idle busy", 32'(bsy[0]), 32'd0);
            step();
        end

        check_frame(0, 8'hA5, 20'({1'b1, 8'hA5, 1'b0}), 10, "8n1");
        check_frame(1, 8'hA5, 20'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, "8e1");
        check_frame(2, 8'hA5, 20'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, "8o1");
        check_frame(3, 8'h7F, 20'({2'b11, 7'h7F, 1'b0}), 10, "7n2");

        // Back-to-back with a queued word and a 20-cycle hold-off while full.
        exp_b2b = {1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0};
        din[0] = 8'h55;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        for (int k = 0; k < 80; k++) begin
            exp_rdy = (k <= 8) || (k >= 40);
            chk("b2b ser",   32'(ser[0]), 32'(exp_b2b[k / 4]));
            chk("b2b busy",  32'(bsy[0]), 32'd1);
            chk("b2b done",  32'(dn[0]),  32'(k == 40));
            chk("b2b ready", 32'(rdy[0]), 32'(exp_rdy));
            if (k == 8) begin
                din[0] = 8'h0F;
                vld[0] = 1'b1;
            end else if (k >= 9 && k <= 28) begin
                din[0] = 8'($urandom);
                vld[0] = 1'b1;
            end else if (k == 29) begin
                vld[0] = 1'b0;
            end
            step();
        end
        chk("b2b done_end", 32'(dn[0]),  32'd1);
        chk("b2b busy_end", 32'(bsy[0]), 32'd0);
        chk("b2b ser_end",  32'(ser[0]), 32'd1);
        step();

        // Reset during data bit 3 of 0xA5 (frame cycles 16..19).
        din[0] = 8'hA5;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        repeat (17) step();
        chk("mid ser pre",  32'(ser[0]), 32'd0);
        chk("mid busy pre", 32'(bsy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst ser",   32'(ser[0]), 32'd1);
        chk("mid rst busy",  32'(bsy[0]), 32'd0);
        chk("mid rst ready", 32'(rdy[0]), 32'd0);
        chk("mid rst done",  32'(dn[0]),  32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("mid ready after", 32'(rdy[0]), 32'd1);
        for (int k = 0; k < 48; k++) begin
            chk("mid quiet ser",  32'(ser[0]), 32'd1);
            chk("mid quiet busy", 32'(bsy[0]), 32'd0);
            chk("mid quiet done", 32'(dn[0]),  32'd0);
            step();
        end

        check_frame(0, 8'h3C, 20'({1'b1, 8'h3C, 1'b0}), 10, "post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule
